// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the Ascon decrypt-and-verify block.
package ascon_pkg;

    localparam int unsigned BlkBytes = 16;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StWaitTag,
        StCompare,
        StRelease,
        StFail,
        StDone
    } state_e;

    // Keep the low rem bytes of a block; rem = 0 means the whole block is valid.
    function automatic logic [127:0] byte_mask(input logic [3:0] rem);
        logic [127:0] m;
        m = '0;
        for (int unsigned i = 0; i < BlkBytes; i++) begin
            m[8*i +: 8] = (rem == 4'd0 || i < {28'd0, rem}) ? 8'hff : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/ascon_decrypt_verify_if.sv
// Handshake and control signals between the decrypt-verify block and its environment.
interface ascon_decrypt_verify_if #(
    parameter int unsigned LEN_W = 32
);
    logic             start;
    logic [LEN_W-1:0] ct_len;
    logic [127:0]     exp_tag;
    logic             blk_valid;
    logic [127:0]     blk_data;
    logic             blk_ready;
    logic             calc_tag_valid;
    logic [127:0]     calc_tag;
    logic             pt_valid;
    logic [127:0]     pt_data;
    logic             pt_last;
    logic             pt_ready;
    logic             auth_ok;
    logic             auth_fail;
    logic             len_err;
    logic             busy;

    modport master (
        output start, ct_len, exp_tag, blk_valid, blk_data, calc_tag_valid, calc_tag, pt_ready,
        input  blk_ready, pt_valid, pt_data, pt_last, auth_ok, auth_fail, len_err, busy
    );

    modport slave (
        input  start, ct_len, exp_tag, blk_valid, blk_data, calc_tag_valid, calc_tag, pt_ready,
        output blk_ready, pt_valid, pt_data, pt_last, auth_ok, auth_fail, len_err, busy
    );
endinterface

// File: rtl/ascon_pt_buffer.sv
// Plaintext holding buffer: one write port, one combinational read port, single-cycle clear.
module ascon_pt_buffer #(
    parameter int unsigned MAX_BLKS = 4,
    parameter int unsigned AddrW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [127:0]     wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [127:0]     rdata_o
);
    logic [127:0] mem_q [MAX_BLKS];
    logic [127:0] mem_d [MAX_BLKS];

    always_comb begin
        mem_d = mem_q;
        if (clr_i) begin
            for (int unsigned i = 0; i < MAX_BLKS; i++) mem_d[i] = '0;
        end else if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MAX_BLKS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ascon_decrypt_verify.sv
// Buffers decrypted blocks, compares tags in constant time and releases plaintext
// only after successful authentication; wipes buffer and tags on failure.
module ascon_decrypt_verify
    import ascon_pkg::*;
#(
    parameter int unsigned MAX_BLKS = 4,
    parameter int unsigned LEN_W    = 32
) (
    input logic                   clk,
    input logic                   rst,
    ascon_decrypt_verify_if.slave bus
);
    localparam int unsigned CntW  = $clog2(MAX_BLKS + 1);
    localparam int unsigned AddrW = (MAX_BLKS > 1) ? $clog2(MAX_BLKS) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] nblk_q, nblk_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [3:0]      rem_q, rem_d;
    logic [127:0]    exp_tag_q, exp_tag_d, calc_tag_q, calc_tag_d;
    logic            len_err_q, len_err_d;

    logic [LEN_W-1:0] nblk_full;
    logic             diff, wr_last, rd_last;
    logic             buf_we, buf_clr;
    logic [127:0]     buf_wdata, buf_rdata;
    logic             blk_ready_c, pt_valid_c, auth_ok_c, auth_fail_c, pt_valid_o;

    assign nblk_full = LEN_W'(bus.ct_len >> 4) + LEN_W'(|bus.ct_len[3:0]);
    // Full-width OR reduction: timing does not depend on the mismatch position.
    assign diff      = |(calc_tag_q ^ exp_tag_q);
    assign wr_last   = (wr_idx_q == nblk_q - CntW'(1));
    assign rd_last   = (rd_idx_q == nblk_q - CntW'(1));
    assign buf_wdata = wr_last ? (bus.blk_data & byte_mask(rem_q)) : bus.blk_data;

    always_comb begin
        state_d     = state_q;
        nblk_d      = nblk_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        rem_d       = rem_q;
        exp_tag_d   = exp_tag_q;
        calc_tag_d  = calc_tag_q;
        len_err_d   = 1'b0;
        buf_we      = 1'b0;
        buf_clr     = 1'b0;
        blk_ready_c = 1'b0;
        pt_valid_c  = 1'b0;
        auth_ok_c   = 1'b0;
        auth_fail_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (nblk_full > LEN_W'(MAX_BLKS)) begin
                        len_err_d = 1'b1;
                    end else begin
                        exp_tag_d = bus.exp_tag;
                        nblk_d    = CntW'(nblk_full);
                        rem_d     = bus.ct_len[3:0];
                        wr_idx_d  = '0;
                        rd_idx_d  = '0;
                        state_d   = (nblk_full == '0) ? StWaitTag : StCollect;
                    end
                end
            end
            StCollect: begin
                blk_ready_c = 1'b1;
                if (bus.blk_valid) begin
                    buf_we   = 1'b1;
                    wr_idx_d = wr_idx_q + CntW'(1);
                    if (wr_last) state_d = StWaitTag;
                end
            end
            StWaitTag: begin
                if (bus.calc_tag_valid) begin
                    calc_tag_d = bus.calc_tag;
                    state_d    = StCompare;
                end
            end
            StCompare: begin
                auth_ok_c   = ~diff;
                auth_fail_c = diff;
                state_d     = diff ? StFail : StRelease;
            end
            StRelease: begin
                if (nblk_q == '0) begin
                    state_d = StDone;
                end else begin
                    pt_valid_c = 1'b1;
                    if (bus.pt_ready) begin
                        rd_idx_d = rd_idx_q + CntW'(1);
                        if (rd_last) state_d = StDone;
                    end
                end
            end
            StFail: begin
                buf_clr    = 1'b1;
                exp_tag_d  = '0;
                calc_tag_d = '0;
                state_d    = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            nblk_q     <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            rem_q      <= '0;
            exp_tag_q  <= '0;
            calc_tag_q <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nblk_q     <= nblk_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            rem_q      <= rem_d;
            exp_tag_q  <= exp_tag_d;
            calc_tag_q <= calc_tag_d;
            len_err_q  <= len_err_d;
        end
    end

    ascon_pt_buffer #(
        .MAX_BLKS (MAX_BLKS),
        .AddrW    (AddrW)
    ) u_buf (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (buf_clr),
        .we_i    (buf_we),
        .waddr_i (wr_idx_q[AddrW-1:0]),
        .wdata_i (buf_wdata),
        .raddr_i (rd_idx_q[AddrW-1:0]),
        .rdata_o (buf_rdata)
    );

    // Outputs are forced low combinationally while rst is held.
    assign pt_valid_o    = pt_valid_c & ~rst;
    assign bus.pt_valid  = pt_valid_o;
    assign bus.pt_data   = pt_valid_o ? buf_rdata : '0;
    assign bus.pt_last   = pt_valid_o & rd_last;
    assign bus.blk_ready = blk_ready_c & ~rst;
    assign bus.auth_ok   = auth_ok_c & ~rst;
    assign bus.auth_fail = auth_fail_c & ~rst;
    assign bus.len_err   = len_err_q & ~rst;
    assign bus.busy      = (state_q != StIdle) & ~rst;
endmodule

// File: tb/tb_ascon_decrypt_verify.sv
// Directed bench for ascon_decrypt_verify with a queue-based scoreboard and monitor.
module tb_ascon_decrypt_verify;
    localparam int unsigned LEN_W = 32;
    localparam logic [127:0] Tag = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] A0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] A1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] A2  = 128'h202122232425262728292a2b2c2d2e2f;
    localparam logic [127:0] A3  = 128'h303132333435363738393a3b3c3d3e3f;
    localparam logic [127:0] A3m = 128'h0000323334353637_38393a3b3c3d3e3f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ascon_decrypt_verify_if #(.LEN_W(LEN_W)) bus ();

    ascon_decrypt_verify #(
        .MAX_BLKS (4),
        .LEN_W    (LEN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tag_cyc = 0;
    int auth_cyc = 0;
    int idle_bad = 0;
    logic [128:0] beat_q [$];   // {last, data}
    logic         res_q  [$];   // 1 = expect auth_fail

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected beats and auth results whenever the DUT presents them.
    logic         stall_prev = 1'b0;
    logic [127:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.pt_valid && bus.pt_data != '0) idle_bad++;
            if (bus.pt_valid && stall_prev) check("pt_stable", {1'b0, bus.pt_data}, {1'b0, prev_data});
            if (bus.pt_valid && bus.pt_ready) begin
                if (beat_q.size() == 0) check("pt_unexpected", 129'd1, 129'd0);
                else check("pt_beat", {bus.pt_last, bus.pt_data}, beat_q.pop_front());
            end
            if (bus.auth_ok || bus.auth_fail) begin
                auth_cyc = cyc;
                if (res_q.size() == 0) check("auth_unexpected", 129'd1, 129'd0);
                else check("auth_result", {127'd0, bus.auth_ok, bus.auth_fail},
                           {127'd0, ~res_q[0], res_q[0]});
                if (res_q.size() != 0) void'(res_q.pop_front());
            end
            stall_prev = bus.pt_valid && !bus.pt_ready;
            prev_data  = bus.pt_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [128:0] outs();
        return {1'b0, bus.pt_data} | {122'd0, bus.blk_ready, bus.pt_valid, bus.pt_last,
                                      bus.auth_ok, bus.auth_fail, bus.len_err, bus.busy};
    endfunction

    task automatic do_start(input logic [LEN_W-1:0] len, input logic [127:0] tag);
        bus.start = 1'b1; bus.ct_len = len; bus.exp_tag = tag;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d);
        bus.blk_valid = 1'b1; bus.blk_data = d;
        for (int i = 0; i < 20; i++) begin
            if (bus.blk_ready) begin
                tick();
                bus.blk_valid = 1'b0;
                return;
            end
            tick();
        end
        bus.blk_valid = 1'b0;
        check("blk_timeout", 129'd0, 129'd1);
    endtask

    task automatic send_tag(input logic [127:0] t);
        bus.calc_tag_valid = 1'b1; bus.calc_tag = t; tag_cyc = cyc;
        tick();
        bus.calc_tag_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        if (bus.busy) check("idle_timeout", 129'd0, 129'd1);
    endtask

    task automatic four_blocks(input logic [127:0] last);
        send_block(A0); send_block(A1); send_block(A2); send_block(last);
    endtask

    int n, lat_hi, lat_lo;

    initial begin
        bus.start = 0; bus.ct_len = '0; bus.exp_tag = '0; bus.blk_valid = 0; bus.blk_data = '0;
        bus.calc_tag_valid = 0; bus.calc_tag = '0; bus.pt_ready = 1;
        tick(); tick();
        check("outs_in_reset", outs(), 129'd0);
        rst = 1'b0;
        tick();
        check("outs_after_reset", outs(), 129'd0);

        // Authentic 62-byte message
        res_q.push_back(1'b0);
        beat_q.push_back({1'b0, A0}); beat_q.push_back({1'b0, A1});
        beat_q.push_back({1'b0, A2}); beat_q.push_back({1'b1, A3m});
        do_start(62, Tag);
        check("busy_collect", {128'd0, bus.busy}, 129'd1);
        four_blocks(A3);
        send_tag(Tag);
        wait_idle(n);
        check("ok_latency", 129'(auth_cyc - tag_cyc), 129'd1);
        check("ok_beats_drained", 129'(beat_q.size()), 129'd0);

        // Tag mismatch in the top bit, then the bottom bit
        res_q.push_back(1'b1);
        do_start(62, Tag); four_blocks(A3); send_tag(Tag ^ {1'b1, 127'd0});
        wait_idle(n);
        lat_hi = auth_cyc - tag_cyc;
        res_q.push_back(1'b1);
        do_start(62, Tag); four_blocks(A3); send_tag(Tag ^ 128'd1);
        wait_idle(n);
        lat_lo = auth_cyc - tag_cyc;
        check("fail_latency_hi", 129'(lat_hi), 129'd1);
        check("fail_latency_lo", 129'(lat_lo), 129'd1);
        check("fail_res_drained", 129'(res_q.size()), 129'd0);

        // Over-length message
        do_start(80, Tag);
        check("len_err_pulse", {127'd0, bus.len_err, bus.busy}, 129'd2);
        tick();
        check("len_err_cleared", {127'd0, bus.len_err, bus.busy}, 129'd0);

        // Empty message
        res_q.push_back(1'b0);
        do_start(0, Tag);
        check("empty_wait_tag", {128'd0, bus.busy}, 129'd1);
        send_tag(Tag);
        wait_idle(n);
        check("empty_idle_within_4", 129'(n + 1 <= 4), 129'd1);
        check("empty_res_drained", 129'(res_q.size()), 129'd0);

        // 64-byte message, stray start while busy, then back-pressure mid-release
        res_q.push_back(1'b0);
        beat_q.push_back({1'b0, A0}); beat_q.push_back({1'b0, A1});
        beat_q.push_back({1'b0, A2}); beat_q.push_back({1'b1, A3});
        do_start(64, Tag);
        do_start(80, 128'd0);
        check("start_busy_ignored", {127'd0, bus.len_err, bus.busy}, 129'd1);
        four_blocks(A3);
        send_tag(Tag);
        n = 0;
        while (!bus.pt_valid && n < 10) begin tick(); n++; end
        check("release_seen", {128'd0, bus.pt_valid}, 129'd1);
        tick();
        bus.pt_ready = 1'b0;
        tick(); tick(); tick();
        bus.pt_ready = 1'b1;
        wait_idle(n);
        check("stall_beats_drained", 129'(beat_q.size()), 129'd0);

        // Reset in the middle of collection, then a clean message
        do_start(64, Tag);
        send_block(A0); send_block(A1);
        rst = 1'b1;
        #1;
        check("outs_mid_reset", outs(), 129'd0);
        tick();
        check("outs_reset_held", outs(), 129'd0);
        rst = 1'b0;
        tick();
        check("idle_after_reset", {128'd0, bus.busy}, 129'd0);
        res_q.push_back(1'b0);
        beat_q.push_back({1'b0, A0}); beat_q.push_back({1'b0, A1});
        beat_q.push_back({1'b0, A2}); beat_q.push_back({1'b1, A3m});
        do_start(62, Tag); four_blocks(A3); send_tag(Tag);
        wait_idle(n);
        check("post_reset_drained", 129'(beat_q.size() + res_q.size()), 129'd0);
        check("pt_data_zero_when_idle", 129'(idle_bad), 129'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
